// File: rtl/oled_mode_pkg.sv
// Shared constants for the OLED display-mode controller: mux select codes,
// frame geometry default, FSM state encoding and the switch priority resolver.
package oled_mode_pkg;

  localparam logic [1:0] MODE_BAR   = 2'd0;
  localparam logic [1:0] MODE_THIN  = 2'd1;
  localparam logic [1:0] MODE_THICK = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  localparam int NUM_PIXELS_DEFAULT = 6144;
  localparam int IDX_W              = 13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_BLANK    = 2'd2
  } state_t;

  // Thin border wins over thick, thick over off; nothing set means colour bar.
  function automatic logic [1:0] resolve_mode(input logic thin, input logic thick,
                                              input logic off);
    if (thin)       return MODE_THIN;
    else if (thick) return MODE_THICK;
    else if (off)   return MODE_OFF;
    else            return MODE_BAR;
  endfunction

endpackage

// File: rtl/oled_mode_ctrl_sw_debounce.sv
// One board switch: two-flop synchroniser followed by a run-length debouncer
// that accepts a new level only after DEBOUNCE_CYCLES unbroken cycles.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clock,
  input  logic resetn,
  input  logic sw_raw,
  output logic sw_level
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      sw_level <= 1'b0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
      // A single cycle back at the accepted level restarts the run.
      if (sync_p1 == sw_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_level <= sync_p1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_mode_ctrl.sv
// Frame-synchronous OLED pixel-source selector: debounced switch priority,
// mode changes deferred to start of frame with optional whole-frame blanking.
module oled_mode_ctrl
  import oled_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLANK_FRAMES    = 2,
  parameter int NUM_PIXELS      = NUM_PIXELS_DEFAULT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sw_thin,
  input  logic             sw_thick,
  input  logic             sw_off,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [1:0]       mode,
  output logic             blank,
  output logic             mode_changed,
  output logic             busy
);

  localparam int               FC_W     = $clog2(BLANK_FRAMES + 2);
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(BLANK_FRAMES);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  logic             db_thin;
  logic             db_thick;
  logic             db_off;
  logic [1:0]       target;
  logic [IDX_W-1:0] prev_idx;
  logic             sof;
  state_t           state;
  logic [1:0]       pending;
  logic [FC_W-1:0]  frame_cnt;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_thin (
    .clock(clock), .resetn(resetn), .sw_raw(sw_thin), .sw_level(db_thin)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_thick (
    .clock(clock), .resetn(resetn), .sw_raw(sw_thick), .sw_level(db_thick)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_off (
    .clock(clock), .resetn(resetn), .sw_raw(sw_off), .sw_level(db_off)
  );

  assign target = resolve_mode(db_thin, db_thick, db_off);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) prev_idx <= '0;
    else         prev_idx <= pixel_index;
  end

  // Only a genuine wrap from an in-frame index counts; a stalled zero does not.
  assign sof  = (pixel_index == '0) && (prev_idx != '0) && (prev_idx <= LAST_IDX);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      pending      <= MODE_BAR;
      frame_cnt    <= '0;
      mode         <= MODE_BAR;
      blank        <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (target != mode) begin
            pending <= target;
            state   <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          pending <= target;
          if (sof) begin
            if (BLANK_FRAMES == 0) begin
              mode         <= pending;
              mode_changed <= (pending != mode);
              state        <= ST_IDLE;
            end else begin
              blank     <= 1'b1;
              frame_cnt <= FC_LOAD;
              state     <= ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          pending <= target;
          // A target that reverted to the current mode still runs to completion.
          if (sof) begin
            frame_cnt <= frame_cnt - 1'b1;
            if (frame_cnt == FC_LAST) begin
              mode         <= pending;
              mode_changed <= (pending != mode);
              blank        <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/oled_mode_ctrl.md
# oled_mode_ctrl

Frame-synchronous display-mode controller that sequences the OLED pixel-source mux. It debounces the three mode switches and resolves their priority. Each mode change is deferred to a frame boundary, so a frame never mixes sources, and the panel is held blank for a programmable number of frames around the switch-over. It sits between the board switches and the pixel mux and drives the mux select plus a blank override.

## Interface
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles before a switch level is accepted
- BLANK_FRAMES, 2, whole frames forced black during a mode change (0 = no blanking)
- NUM_PIXELS, 6144, pixels per frame (96x64); pixel_index runs 0..NUM_PIXELS-1
- clock  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- sw_thin  input  1  raw switch, thin-border request (highest priority)
- sw_thick  input  1  raw switch, thick-border request
- sw_off  input  1  raw switch, colour-bar off request (lowest priority)
- pixel_index  input  13  current pixel index from the OLED driver
- mode  output  2  mux select: 0 = colour bar, 1 = thin border, 2 = thick border, 3 = off
- blank  output  1  1 forces pixel_data to 0 downstream
- mode_changed  output  1  one-cycle pulse on commit of a new mode
- busy  output  1  1 while a change is pending or blanking

## Operation
- Each switch passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back to the debounced level clears that switch's counter.
- Target mode, combinational from the debounced switches: thin → 1; else thick → 2; else off → 3; else 0.
- Start of frame (sof): prev_idx is registered every cycle. sof = (pixel_index == 0) && (prev_idx != 0). sof therefore fires once per wrap, and a stalled index of 0 does not retrigger it.
- FSM states: IDLE, WAIT_SOF, BLANK.
  - IDLE: if target != mode, then pending <= target and go to WAIT_SOF.
  - WAIT_SOF: pending tracks target every cycle. On sof:
    - if BLANK_FRAMES = 0: commit and go to IDLE;
    - otherwise: blank <= 1, frame_cnt <= BLANK_FRAMES, go to BLANK.
  - BLANK: pending tracks target every cycle. On each sof, frame_cnt decrements. On the sof where frame_cnt = 1: commit, blank <= 0, go to IDLE.
  - Commit: mode <= pending. mode_changed pulses only if pending != mode.
- Target reverting to the current mode during WAIT_SOF or BLANK:
  - the sequence still completes;
  - the commit is a no-op and no pulse is generated.
- busy = (state != IDLE).
- Reset mid-sequence: all state and outputs return to reset values immediately. Any pending change is discarded.

## Timing
- Reset values:
  - mode = 0, blank = 0, mode_changed = 0, busy = 0;
  - debounced levels = 0, counters = 0, prev_idx = 0, state = IDLE.
- Switch edge to target change: 2 synchroniser cycles + DEBOUNCE_CYCLES.
- Target change to busy = 1: 1 cycle.
- mode, blank and mode_changed are registered.
  - They update on the edge where sof is sampled high.
  - They are therefore valid while pixel_index = 0 is presented the cycle after.
  - The downstream mux must register pixel_data with 1-cycle latency to align.
- Blank duration: exactly BLANK_FRAMES × NUM_PIXELS pixel periods, from one sof to a later sof.
- Minimum mode dwell: one frame. A new change cannot commit before the next sof after returning to IDLE.

## Structure
- Package oled_mode_pkg holds:
  - MODE_BAR / MODE_THIN / MODE_THICK / MODE_OFF 2-bit constants;
  - the NUM_PIXELS default;
  - the FSM state encoding.
- Sub-module sw_debounce: parameterised on DEBOUNCE_CYCLES, containing the synchroniser, counter and debounced output. It is instantiated three times.
- Top-level oled_mode_ctrl contains the priority encoder, sof detector, frame counter and FSM.

## Test plan
- Reset: assert resetn = 0 mid-BLANK → mode = 0, blank = 0, busy = 0 within the same cycle. After release there is no commit until a fresh debounce.
- Debounce (DEBOUNCE_CYCLES = 8): sw_thin toggles every 3 cycles for 50 cycles, then holds 1 → busy rises exactly 2 + 8 + 1 cycles after the final edge.
- Frame alignment (BLANK_FRAMES = 2): set sw_thick mid-frame.
  - blank = 1 from the next sof;
  - mode goes 0 → 2 with a single mode_changed pulse at the second following sof;
  - blank = 0 at that same sof.
- Priority: sw_off and sw_thick both stable → commit mode = 2. Then add sw_thin → mode = 1 after the next sequence.
- Revert: set sw_off, then clear it during BLANK → blank ends on schedule, mode stays 0, no mode_changed pulse.
- BLANK_FRAMES = 0 with pixel_index stalled at 0 for 10 cycles: one sof only, mode commits once, blank never asserts.
